// File: rtl/lsu_bus_if.sv
// lsu_bus_if: single-port data bus between the load/store sequencer and memory.
//   req   : transaction request, held until ack is seen
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   be    : byte enables, bit n selects byte lane n
//   wdata : lane-replicated write data
//   ack   : transaction completion (single cycle)
//   rdata : read word, valid together with ack
interface lsu_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store sequencer between the RV32I MEM stage and a
// req/ack data bus. Launches word-aligned transactions with byte enables,
// stalls the pipeline while a transaction is in flight, and returns
// sign/zero-extended load data. Misaligned accesses and bus timeouts are
// reported as one-cycle pulses.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_mem_re/i_mem_we  MEM-stage load/store request (store wins if both)
//   i_funct3           access size/sign (B, H, W, BU, HU; others act as W)
//   i_addr, i_wdata    byte address and store data
//   i_flush            squashes the MEM-stage request before launch
//   o_stall            holds IF..MEM while an access is being serviced
//   o_rdata/_vld       extended load result, valid for one cycle
//   o_misaligned       pulse: access rejected for alignment
//   o_bus_err          pulse: bus did not ack in time
//   bus                master side of lsu_bus_if
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_re,
    input  logic        i_mem_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic        o_misaligned,
    output logic        o_bus_err,
    lsu_bus_if.master   bus
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Last counter value still allowed to wait; unused when the timeout is off.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             access;
    logic [1:0]       size;
    logic             misaligned;
    logic             launch;
    logic             ack_hit;
    logic             timeout_hit;
    logic [3:0]       be_nxt;
    logic [31:0]      wdata_nxt;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;

    // Shift the bus word so the addressed byte sits in lane 0, then extend.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (sz)
            SZ_B:    r = {{24{~uns & s[7]}}, s[7:0]};
            SZ_H:    r = {{16{~uns & s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    assign access = (i_mem_re | i_mem_we) & ~i_flush;

    // funct3[1:0] = 11 is undefined and falls through to a word access.
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   size = SZ_B;
            2'b01:   size = SZ_H;
            default: size = SZ_W;
        endcase
    end

    assign misaligned = ((size == SZ_H) & i_addr[0]) |
                        ((size == SZ_W) & (|i_addr[1:0]));

    always_comb begin
        case (size)
            SZ_B: begin
                be_nxt    = 4'b0001 << i_addr[1:0];
                wdata_nxt = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                be_nxt    = 4'b0011 << i_addr[1:0];
                wdata_nxt = {2{i_wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = i_wdata;
            end
        endcase
    end

    // Next state and stall. Flush only matters before launch; once in REQ
    // the bus transaction has to run to completion.
    always_comb begin
        state_nxt   = state;
        o_stall     = 1'b0;
        launch      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    o_stall   = 1'b1;
                    launch    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (bus.ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            // DONE releases the pipeline for one cycle and never relaunches.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.req      <= 1'b0;
            bus.we       <= 1'b0;
            bus.addr     <= '0;
            bus.be       <= '0;
            bus.wdata    <= '0;
            size_q       <= SZ_W;
            uns_q        <= 1'b0;
            off_q        <= '0;
            cnt          <= '0;
            o_rdata      <= '0;
            o_rdata_vld  <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_misaligned <= (state == IDLE) & access & misaligned;
            o_rdata_vld  <= ack_hit & ~bus.we;
            o_bus_err    <= timeout_hit;

            if (launch) begin
                bus.req   <= 1'b1;
                bus.we    <= i_mem_we;
                bus.addr  <= {i_addr[31:2], 2'b00};
                bus.be    <= be_nxt;
                bus.wdata <= wdata_nxt;
                size_q    <= size;
                uns_q     <= i_funct3[2];
                off_q     <= i_addr[1:0];
                cnt       <= '0;
            end else if ((state == REQ) && !bus.ack) begin
                cnt <= cnt + 1'b1;
            end

            if (ack_hit || timeout_hit) begin
                bus.req <= 1'b0;
            end

            if (ack_hit && !bus.we) begin
                o_rdata <= extend_load(bus.rdata, off_q, size_q, uns_q);
            end else if (timeout_hit) begin
                o_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed plus randomized bench for lsu_bus_ctrl with a
// transaction-level reference model (byte counts, shifts and arithmetic
// sign extension) and a bus responder with a programmable wait count.
module tb_lsu_bus_ctrl;

    localparam int T = 4;

    logic        clk;
    logic        i_rst_n;
    logic        i_mem_re;
    logic        i_mem_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_flush;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_vld;
    logic        o_misaligned;
    logic        o_bus_err;

    lsu_bus_if bus ();

    lsu_bus_ctrl #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_mem_re     (i_mem_re),
        .i_mem_we     (i_mem_we),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_rdata      (o_rdata),
        .o_rdata_vld  (o_rdata_vld),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .bus          (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00)      return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else                       return 4;
    endfunction

    function automatic bit is_mis(input int n, input logic [31:0] a);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] model_be(input int n, input logic [31:0] a);
        int v;
        v = ((1 << n) - 1) << a[1:0];
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int n, input logic [31:0] wd);
        logic [31:0] r;
        for (int lane = 0; lane < 4; lane++)
            r[lane*8 +: 8] = wd[(lane % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int n, input bit uns,
                                               input logic [31:0] a, input logic [31:0] word);
        longint v;
        longint full;
        full = longint'(64'sd1) << (8 * n);
        v = (longint'({32'd0, word}) >> (8 * int'(a[1:0]))) & (full - 1);
        if (!uns && n < 4 && v >= (full / 2)) v = v - full;
        return v[31:0];
    endfunction

    // ---------------- one access with the bus responder ----------------
    task automatic do_access(input bit re, input bit we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input bit flush, input int w, input logic [31:0] word,
                             output logic [31:0] got, output int stalls);
        int  n;
        bit  acc;
        bit  mis;
        bit  tmo;
        int  reqc;
        n      = nbytes(f3);
        acc    = (re || we) && !flush;
        mis    = acc && is_mis(n, addr);
        stalls = 0;
        got    = '0;

        @(negedge clk);
        i_mem_re  = re;
        i_mem_we  = we;
        i_funct3  = f3;
        i_addr    = addr;
        i_wdata   = wdata;
        i_flush   = flush;
        bus.ack   = 1'($urandom % 2);
        bus.rdata = $urandom;
        #1;
        chk("idle_req", {31'd0, bus.req}, 32'd0);
        chk("idle_vld", {31'd0, o_rdata_vld}, 32'd0);
        chk("idle_err", {31'd0, o_bus_err}, 32'd0);
        chk("idle_mis", {31'd0, o_misaligned}, 32'd0);
        chk("launch_stall", {31'd0, o_stall}, {31'd0, acc && !mis});
        stalls += int'(o_stall);

        if (!acc || mis) begin
            @(negedge clk);
            i_mem_re = 1'b0;
            i_mem_we = 1'b0;
            bus.ack  = 1'b0;
            #1;
            chk("mis_pulse", {31'd0, o_misaligned}, {31'd0, mis});
            chk("mis_req", {31'd0, bus.req}, 32'd0);
            chk("mis_stall", {31'd0, o_stall}, 32'd0);
            return;
        end

        tmo  = (w >= T);
        reqc = tmo ? T : w + 1;
        for (int k = 0; k < reqc; k++) begin
            @(negedge clk);
            bus.ack   = (k == w);
            bus.rdata = (k == w) ? word : $urandom;
            i_flush   = 1'($urandom % 2);
            i_addr    = $urandom;
            i_wdata   = $urandom;
            #1;
            chk("req_req", {31'd0, bus.req}, 32'd1);
            chk("req_we", {31'd0, bus.we}, {31'd0, we});
            chk("req_addr", bus.addr, addr & 32'hFFFF_FFFC);
            chk("req_be", {28'd0, bus.be}, {28'd0, model_be(n, addr)});
            if (we) chk("req_wdata", bus.wdata, model_wdata(n, wdata));
            chk("req_stall", {31'd0, o_stall}, 32'd1);
            chk("req_vld", {31'd0, o_rdata_vld}, 32'd0);
            stalls += int'(o_stall);
        end

        // DONE cycle: throw a spurious ack and a new request at it.
        @(negedge clk);
        bus.ack   = 1'($urandom % 2);
        bus.rdata = $urandom;
        i_mem_re  = 1'($urandom % 2);
        i_mem_we  = 1'($urandom % 2);
        i_funct3  = 3'($urandom);
        i_addr    = $urandom;
        i_flush   = 1'b0;
        #1;
        chk("done_stall", {31'd0, o_stall}, 32'd0);
        chk("done_req", {31'd0, bus.req}, 32'd0);
        chk("done_vld", {31'd0, o_rdata_vld}, {31'd0, !we && !tmo});
        chk("done_err", {31'd0, o_bus_err}, {31'd0, tmo});
        if (tmo)
            chk("done_rdata_tmo", o_rdata, 32'd0);
        else if (!we)
            chk("done_rdata", o_rdata, model_load(n, f3[2], addr, word));
        got = o_rdata;
        chk("stall_cnt", stalls, reqc + 1);
    endtask

    task automatic quiesce();
        @(negedge clk);
        i_mem_re = 1'b0;
        i_mem_we = 1'b0;
        i_flush  = 1'b0;
        bus.ack  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          st;
        i_rst_n   = 1'b0;
        i_mem_re  = 1'b0;
        i_mem_we  = 1'b0;
        i_funct3  = 3'd0;
        i_addr    = '0;
        i_wdata   = '0;
        i_flush   = 1'b0;
        bus.ack   = 1'b0;
        bus.rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, bus.req}, 32'd0);
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_be", {28'd0, bus.be}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_vld", {31'd0, o_rdata_vld}, 32'd0);
        chk("rst_mis", {31'd0, o_misaligned}, 32'd0);
        chk("rst_err", {31'd0, o_bus_err}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        // Directed cases
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, got, st);
        chk("lw_rdata", got, 32'hDEADBEEF);
        chk("lw_stalls", st, 2);
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233, got, st);
        chk("lb_rdata", got, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80112233, got, st);
        chk("lbu_rdata", got, 32'h00000080);
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80112233, got, st);
        chk("lhu_rdata", got, 32'h00008011);
        do_access(0, 1, 3'b001, 32'h206, 32'h0000ABCD, 0, 3, 32'h0, got, st);
        chk("sh_stalls", st, 5);
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, got, st);
        do_access(1, 0, 3'b010, 32'h180, 32'h0, 0, 20, 32'h12345678, got, st);
        chk("tmo_stalls", st, T + 1);
        do_access(1, 1, 3'b010, 32'h1F0, 32'hCAFEF00D, 0, 1, 32'h0, got, st);

        // Asynchronous reset while a load is waiting for ack
        quiesce();
        i_mem_re = 1'b1;
        i_funct3 = 3'b010;
        i_addr   = 32'h300;
        @(negedge clk);
        #1;
        chk("rst_mid_pre_req", {31'd0, bus.req}, 32'd1);
        i_mem_re = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, bus.req}, 32'd0);
        chk("rst_mid_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_mid_addr", bus.addr, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        do_access(0, 1, 3'b010, 32'h400, 32'h01020304, 0, 1, 32'h0, got, st);
        chk("sw_after_rst_stalls", st, 3);
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 1, 0, 32'h0, got, st);
        chk("flush_stalls", st, 0);

        // Randomized accesses
        for (int i = 0; i < 300; i++) begin
            do_access(1'($urandom % 2), 1'($urandom % 2), 3'($urandom),
                      $urandom, $urandom, ($urandom % 8) == 0,
                      int'($urandom_range(0, 5)), $urandom, got, st);
        end
        quiesce();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
